// File: rtl/green_filter_stream.sv
// rtl/green_filter_stream.sv - two-stage AXI-Stream green-channel gain/threshold filter with line/frame status
// Config is shadowed at each accepted SOF beat; S1 multiplies, S2 saturates/thresholds and drives the output.
module green_filter_stream #(
  parameter int CH_W       = 8,
  parameter int LINE_CNT_W = 12
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [3*CH_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [3*CH_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  cfg_enable,
  input  logic [7:0]            cfg_gain,
  input  logic [CH_W-1:0]       cfg_threshold,
  input  logic                  cfg_err_clr,
  output logic [31:0]           stat_frame_cnt,
  output logic [LINE_CNT_W-1:0] stat_line_len,
  output logic                  stat_line_err
);

  localparam int PW  = 3 * CH_W;
  localparam int PRW = CH_W + 8;

  logic                  en_q, en_d;
  logic [7:0]            gain_q, gain_d;
  logic [CH_W-1:0]       thr_q, thr_d;

  logic                  v1_q, v1_d;
  logic [PW-1:0]         pix1_q, pix1_d;
  logic                  user1_q, user1_d;
  logic                  last1_q, last1_d;
  logic                  en1_q, en1_d;
  logic [CH_W-1:0]       thr1_q, thr1_d;
  logic [PRW-1:0]        prod1_q, prod1_d;

  logic                  v2_q, v2_d;
  logic [PW-1:0]         out2_q, out2_d;
  logic                  user2_q, user2_d;
  logic                  last2_q, last2_d;

  logic [LINE_CNT_W-1:0] cnt_q, cnt_d;
  logic [LINE_CNT_W-1:0] len_q, len_d;
  logic [LINE_CNT_W-1:0] ref_q, ref_d;
  logic                  refv_q, refv_d;
  logic                  err_q, err_d;
  logic [31:0]           frame_q, frame_d;

  logic                  adv1, adv2, s_fire, m_fire, sof_fire;
  logic                  eff_en;
  logic [7:0]            eff_gain;
  logic [CH_W-1:0]       eff_thr;
  logic [CH_W+3:0]       prod_sh;
  logic [CH_W-1:0]       g2;
  logic [LINE_CNT_W-1:0] beat_cnt;
  logic                  err_set;

  always_comb begin
    adv2     = !v2_q || m_axis_tready;
    adv1     = !v1_q || adv2;
    s_fire   = s_axis_tvalid && adv1;
    m_fire   = v2_q && m_axis_tready;
    sof_fire = s_fire && s_axis_tuser;

    // The SOF beat itself must already see the freshly sampled config.
    eff_en   = sof_fire ? cfg_enable    : en_q;
    eff_gain = sof_fire ? cfg_gain      : gain_q;
    eff_thr  = sof_fire ? cfg_threshold : thr_q;

    prod_sh = prod1_q[PRW-1:4];
    g2      = (|prod1_q[PRW-1:CH_W+4]) ? {CH_W{1'b1}} : prod_sh[CH_W-1:0];
    if (g2 < thr1_q) g2 = '0;

    en_d    = en_q;
    gain_d  = gain_q;
    thr_d   = thr_q;
    v1_d    = v1_q;
    pix1_d  = pix1_q;
    user1_d = user1_q;
    last1_d = last1_q;
    en1_d   = en1_q;
    thr1_d  = thr1_q;
    prod1_d = prod1_q;
    v2_d    = v2_q;
    out2_d  = out2_q;
    user2_d = user2_q;
    last2_d = last2_q;

    if (sof_fire) begin
      en_d   = cfg_enable;
      gain_d = cfg_gain;
      thr_d  = cfg_threshold;
    end

    if (adv1) begin
      v1_d = s_axis_tvalid;
      if (s_fire) begin
        pix1_d  = s_axis_tdata;
        user1_d = s_axis_tuser;
        last1_d = s_axis_tlast;
        en1_d   = eff_en;
        thr1_d  = eff_thr;
        prod1_d = PRW'(s_axis_tdata[2*CH_W-1:CH_W]) * PRW'(eff_gain);
      end
    end

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        out2_d  = en1_q ? {{CH_W{1'b0}}, g2, {CH_W{1'b0}}} : pix1_q;
        user2_d = user1_q;
        last2_d = last1_q;
      end
    end

    cnt_d    = cnt_q;
    len_d    = len_q;
    ref_d    = ref_q;
    refv_d   = refv_q;
    err_set  = 1'b0;
    beat_cnt = s_axis_tuser ? LINE_CNT_W'(1)
             : ((&cnt_q) ? cnt_q : cnt_q + LINE_CNT_W'(1));
    if (s_fire) begin
      if (s_axis_tlast) begin
        len_d = beat_cnt;
        cnt_d = '0;
        // First complete line of a frame becomes the reference length.
        if (s_axis_tuser || !refv_q) begin
          ref_d  = beat_cnt;
          refv_d = 1'b1;
        end else if (beat_cnt != ref_q) begin
          err_set = 1'b1;
        end
      end else begin
        cnt_d = beat_cnt;
        if (s_axis_tuser) refv_d = 1'b0;
      end
    end
    err_d = err_set || (err_q && !cfg_err_clr);

    frame_d = frame_q;
    if (m_fire && user2_q) frame_d = frame_q + 32'd1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      en_q    <= 1'b0;
      gain_q  <= 8'h10;
      thr_q   <= '0;
      v1_q    <= 1'b0;
      pix1_q  <= '0;
      user1_q <= 1'b0;
      last1_q <= 1'b0;
      en1_q   <= 1'b0;
      thr1_q  <= '0;
      prod1_q <= '0;
      v2_q    <= 1'b0;
      out2_q  <= '0;
      user2_q <= 1'b0;
      last2_q <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      ref_q   <= '0;
      refv_q  <= 1'b0;
      err_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      en_q    <= en_d;
      gain_q  <= gain_d;
      thr_q   <= thr_d;
      v1_q    <= v1_d;
      pix1_q  <= pix1_d;
      user1_q <= user1_d;
      last1_q <= last1_d;
      en1_q   <= en1_d;
      thr1_q  <= thr1_d;
      prod1_q <= prod1_d;
      v2_q    <= v2_d;
      out2_q  <= out2_d;
      user2_q <= user2_d;
      last2_q <= last2_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ref_q   <= ref_d;
      refv_q  <= refv_d;
      err_q   <= err_d;
      frame_q <= frame_d;
    end
  end

  assign s_axis_tready  = !v1_q || !v2_q || m_axis_tready;
  assign m_axis_tvalid  = v2_q;
  assign m_axis_tdata   = out2_q;
  assign m_axis_tuser   = user2_q;
  assign m_axis_tlast   = last2_q;
  assign stat_frame_cnt = frame_q;
  assign stat_line_len  = len_q;
  assign stat_line_err  = err_q;

endmodule

// File: tb/tb_green_filter_stream.sv
// tb/tb_green_filter_stream.sv - self-checking bench for green_filter_stream
// Scoreboard model plus directed vectors with literal expectations.
module tb_green_filter_stream;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [23:0] s_axis_tdata = '0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [7:0]  cfg_gain = 8'h10;
  logic [7:0]  cfg_threshold = 8'h00;
  logic        cfg_err_clr = 1'b0;
  logic [31:0] stat_frame_cnt;
  logic [11:0] stat_line_len;
  logic        stat_line_err;

  green_filter_stream dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .cfg_enable(cfg_enable), .cfg_gain(cfg_gain), .cfg_threshold(cfg_threshold),
    .cfg_err_clr(cfg_err_clr),
    .stat_frame_cnt(stat_frame_cnt), .stat_line_len(stat_line_len), .stat_line_err(stat_line_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [23:0] d;
    logic        u;
    logic        l;
    int          c;
  } beat_t;

  int compared = 0;
  int mismatched = 0;

  beat_t exp_q[$];
  beat_t got_q[$];
  beat_t e, o;

  int          m_en, m_gain, m_thr;
  int          m_cnt, m_len, m_ref, m_refv, m_err;
  logic [31:0] m_frames;
  int          ncyc = 0;
  int          g, v;
  bit          eset;
  bit          check_lat = 1'b1;
  bit          stall_prev = 1'b0;
  logic [25:0] prev_out;
  int          rdy_mode = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_gain = 16; m_thr = 0;
    m_cnt = 0; m_len = 0; m_ref = 0; m_refv = 0; m_err = 0;
    m_frames = '0;
    exp_q.delete();
    stall_prev = 1'b0;
  endtask

  // Compare process: checks run against model state from earlier cycles, then this cycle's events are applied.
  always @(negedge ACLK) begin
    ncyc++;
    if (ARESET) begin
      model_reset();
    end else begin
      chk("line_len", stat_line_len, m_len);
      chk("line_err", stat_line_err, m_err);
      chk("frame_cnt", stat_frame_cnt, m_frames);
      chk("s_tready", s_axis_tready, (exp_q.size() < 2) || m_axis_tready);
      if (stall_prev) begin
        chk("hold_valid", m_axis_tvalid, 1);
        chk("hold_data", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, prev_out);
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_out = {m_axis_tdata, m_axis_tuser, m_axis_tlast};

      if (m_axis_tvalid && m_axis_tready) begin
        o.d = m_axis_tdata; o.u = m_axis_tuser; o.l = m_axis_tlast; o.c = ncyc;
        got_q.push_back(o);
        if (exp_q.size() == 0) begin
          chk("unexpected_out", m_axis_tdata, 0);
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_axis_tdata, e.d);
          chk("out_user", m_axis_tuser, e.u);
          chk("out_last", m_axis_tlast, e.l);
          if (check_lat) chk("latency", ncyc - e.c, 2);
          if (e.u) m_frames = m_frames + 32'd1;
        end
      end

      eset = 1'b0;
      if (s_axis_tvalid && s_axis_tready) begin
        if (s_axis_tuser) begin
          m_en = cfg_enable; m_gain = cfg_gain; m_thr = cfg_threshold;
        end
        if (m_en != 0) begin
          g = s_axis_tdata[15:8];
          v = (g * m_gain) / 16;
          if (v > 255) v = 255;
          if (v < m_thr) v = 0;
          e.d = {8'h00, 8'(v), 8'h00};
        end else begin
          e.d = s_axis_tdata;
        end
        e.u = s_axis_tuser; e.l = s_axis_tlast; e.c = ncyc;
        exp_q.push_back(e);

        if (s_axis_tuser) begin
          m_cnt = 1; m_refv = 0;
        end else if (m_cnt < 4095) begin
          m_cnt++;
        end
        if (s_axis_tlast) begin
          m_len = m_cnt; m_cnt = 0;
          if (m_refv == 0) begin
            m_ref = m_len; m_refv = 1;
          end else if (m_len != m_ref) begin
            eset = 1'b1;
          end
        end
      end
      m_err = (eset || (m_err != 0 && !cfg_err_clr)) ? 1 : 0;
    end
  end

  initial begin
    int pc;
    pc = 0;
    forever begin
      @(posedge ACLK); #1;
      pc++;
      m_axis_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (pc % 3 == 0) : 1'b0;
    end
  end

  task automatic send(input logic [23:0] d, input logic u, input logic l);
    bit ok;
    ok = 1'b0;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge ACLK); #1;
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic send_line(input int n, input bit sof);
    for (int i = 0; i < n; i++)
      send({8'(i + 1), 8'(i + 2), 8'(i + 3)}, sof && (i == 0), i == n - 1);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic chk_got(input string name, input int idx, input logic [23:0] d);
    if (idx >= got_q.size()) chk({name, "_missing"}, got_q.size(), idx + 1);
    else chk(name, got_q[idx].d, d);
  endtask

  task automatic neg_checks(input int len, input int err, input int frames);
    @(negedge ACLK);
    chk("lit_line_len", stat_line_len, len);
    chk("lit_line_err", stat_line_err, err);
    if (frames >= 0) chk("lit_frame_cnt", stat_frame_cnt, frames);
    @(posedge ACLK); #1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, 0);
    chk("rst_s_tready", s_axis_tready, 1);
    chk("rst_stats", {stat_frame_cnt, stat_line_len, stat_line_err}, 0);
    @(posedge ACLK); #1;

    // Bypass, single-pixel line
    got_q.delete();
    cfg_enable = 1'b0;
    send(24'h123456, 1'b1, 1'b1);
    drain(4);
    chk_got("bypass_data", 0, 24'h123456);
    if (got_q.size() > 0) chk("bypass_ul", {got_q[0].u, got_q[0].l}, 2'b11);
    neg_checks(1, 0, 1);

    // Gain and saturation
    got_q.delete();
    cfg_enable = 1'b1; cfg_gain = 8'h20; cfg_threshold = 8'h00;
    send(24'hAA40BB, 1'b1, 1'b0);
    send(24'h009000, 1'b0, 1'b1);
    drain(4);
    chk_got("gain_2x", 0, 24'h008000);
    chk_got("gain_sat", 1, 24'h00FF00);

    // Threshold
    got_q.delete();
    cfg_gain = 8'h10; cfg_threshold = 8'h30;
    send(24'h112F22, 1'b1, 1'b0);
    send(24'h003000, 1'b0, 1'b1);
    drain(4);
    chk_got("thr_below", 0, 24'h000000);
    chk_got("thr_equal", 1, 24'h003000);

    // Shadowing
    got_q.delete();
    cfg_gain = 8'h10; cfg_threshold = 8'h00;
    send(24'h001000, 1'b1, 1'b0);
    cfg_gain = 8'h20;
    send(24'h001000, 1'b0, 1'b1);
    send(24'h001000, 1'b1, 1'b1);
    drain(4);
    chk_got("shadow_mid", 1, 24'h001000);
    chk_got("shadow_sof", 2, 24'h002000);

    // Backpressure, 1-on/2-off ready
    got_q.delete();
    cfg_gain = 8'h10; cfg_threshold = 8'h00;
    check_lat = 1'b0;
    rdy_mode = 1;
    for (int i = 0; i < 16; i++)
      send({8'h55, 8'(i + 1), 8'hAA}, i == 0, i == 15);
    drain(60);
    rdy_mode = 0;
    drain(3);
    check_lat = 1'b1;
    chk("bp_count", got_q.size(), 16);
    for (int i = 0; i < 16; i++) chk_got("bp_order", i, {8'h00, 8'(i + 1), 8'h00});

    // Line error
    cfg_enable = 1'b0;
    send_line(8, 1'b1);
    send_line(8, 1'b0);
    send_line(7, 1'b0);
    drain(4);
    neg_checks(7, 1, -1);
    cfg_err_clr = 1'b1;
    @(posedge ACLK); #1;
    cfg_err_clr = 1'b0;
    neg_checks(7, 0, -1);
    send_line(4, 1'b1);
    send_line(4, 1'b0);
    drain(4);
    neg_checks(4, 0, -1);

    // Single-pixel reference line
    send_line(1, 1'b1);
    send_line(1, 1'b0);
    send_line(2, 1'b0);
    drain(4);
    neg_checks(2, 1, -1);
    cfg_err_clr = 1'b1;
    @(posedge ACLK); #1;
    cfg_err_clr = 1'b0;

    // Reset mid-line with a full pipeline
    rdy_mode = 2;
    drain(2);
    send(24'h010203, 1'b1, 1'b0);
    send(24'h040506, 1'b0, 1'b0);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("mid_rst_m_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_stats", {stat_frame_cnt, stat_line_len, stat_line_err}, 0);
    chk("mid_rst_s_tready", s_axis_tready, 1);
    @(posedge ACLK); #1;
    got_q.delete();
    rdy_mode = 0;
    drain(10);
    chk("mid_rst_no_out", got_q.size(), 0);
    cfg_enable = 1'b1;
    send(24'h445566, 1'b0, 1'b1);
    drain(4);
    chk_got("rst_cfg_bypass", 0, 24'h445566);
    neg_checks(1, 0, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/green_filter_stream.md
Name: green_filter_stream

Overview:
- AXI4-Stream pixel datapath that sits downstream of the green_filter AXI4-Lite register slave and is configured by it.
- Takes 24-bit RGB pixels and outputs only a gained, thresholded green channel, or passes pixels through unchanged in bypass.
- Returns frame and line status to the register slave for software readback.

Parameters:
CH_W, 8, bits per colour channel (tdata width = 3*CH_W)
LINE_CNT_W, 12, width of beat-per-line counter (max line 4095 pixels)

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
s_axis_tdata  in  24  pixel in: [23:16]=R, [15:8]=G, [7:0]=B
s_axis_tuser  in  1  start of frame, first pixel only
s_axis_tlast  in  1  end of line
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  24  pixel out, same packing
m_axis_tuser  out  1  start of frame, delayed with its pixel
m_axis_tlast  out  1  end of line, delayed with its pixel
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
cfg_enable  in  1  1 = filter, 0 = bypass
cfg_gain  in  8  unsigned 4.4 gain applied to G (0x10 = 1.0)
cfg_threshold  in  8  G' values below this become 0
cfg_err_clr  in  1  one-cycle pulse; clears line_err
stat_frame_cnt  out  32  output frames completed (SOF handshakes at output)
stat_line_len  out  12  beat count of the most recent input line
stat_line_err  out  1  sticky line-length mismatch flag

Behaviour:
- Reset: all pipeline valids 0; m_axis_tvalid=0, m_axis_tdata/tuser/tlast=0; s_axis_tready=1 from the first cycle after reset deasserts; stat_* = 0.
- Active config resets to enable=0, gain=0x10, threshold=0.
- Config shadowing:
  - cfg_* are copied into active registers when an input beat with tuser=1 is accepted (tvalid & tready); that beat and the rest of its frame use the new values.
  - Config changes mid-frame have no effect until the next SOF.
- Pipeline: 2 register stages, S1 (multiply) and S2 (saturate/threshold/output).
  - A stage loads when it is empty or the stage after it advances.
  - s_axis_tready = !v1 | !v2 | m_axis_tready.
  - Full throughput of one pixel per clock.
  - Latency is 2 cycles from input handshake to m_axis_tvalid with continuous ready.
  - tuser/tlast travel with their pixel.
- Backpressure: with m_axis_tready=0, the output holds tdata/tuser/tlast/tvalid stable. At most 2 pixels are buffered, after which s_axis_tready=0. No beat is lost or duplicated.
- Arithmetic, enable=1:
  - prod = G * gain (16 bit).
  - g2 = prod >> 4, saturated to 0xFF if prod[15:12] != 0.
  - If g2 < threshold then g2 = 0.
  - Output {8'h00, g2, 8'h00}.
- Arithmetic, enable=0: output equals input tdata bit-exact, still with 2-cycle latency.
- Line counter (input side):
  - Counts accepted beats, saturating at all-ones.
  - On an accepted beat with tlast: stat_line_len <= count including that beat; counter resets to 0.
  - An accepted tuser beat restarts the counter at 1, discarding any partial line.
- Line error:
  - Reference length is the first complete line of each frame.
  - Any later line in the same frame with a different length sets stat_line_err.
  - A set and cfg_err_clr in the same cycle leaves the flag set.
- Frame counter: increments on each output handshake with tuser=1 and wraps from 0xFFFFFFFF to 0.
- Single-pixel line (tuser=1 and tlast=1 on the same beat): line_len=1, and it is the reference line.
- Reset mid-frame: pipeline contents are dropped, counters and status cleared, active config back to reset values, and no partial output is emitted afterwards.

Test Plan:
- Bypass: enable=0, send pixel 0x123456 with tuser=1, tlast=1 and m_tready=1 -> m_tdata=0x123456, tuser=1, tlast=1 exactly 2 cycles after input handshake; stat_frame_cnt=1.
- Gain/saturate: enable=1, gain=0x20, threshold=0, input G=0x40 -> out 0x008000; input G=0x90 -> out 0x00FF00 (saturated).
- Threshold: gain=0x10, threshold=0x30, G=0x2F -> 0x000000; G=0x30 -> 0x003000.
- Shadowing: change gain from 0x10 to 0x20 mid-frame -> remaining pixels use 1.0 gain; the next SOF pixel with G=0x10 -> out 0x002000.
- Backpressure: stream 16 pixels with incrementing G while toggling m_tready in a 1-on/2-off pattern -> output sequence identical to input order with no drops or duplicates; s_tready low only when both stages are full.
- Line error: frame of lines 8, 8, 7 beats -> stat_line_len=7 and stat_line_err=1; pulse cfg_err_clr -> 0; next frame with lines 4, 4 -> line_err stays 0. Separately, assert ARESET mid-line -> all status 0 and m_tvalid=0 the next cycle.
